// File: rtl/hud_digit_writer_if.sv
// rtl/hud_digit_writer_if.sv - update request and HUD slot write port bundle
interface hud_digit_writer_if #(
    parameter int VALUE_W = 14
);
    logic               upd_valid;
    logic               upd_ready;
    logic [1:0]         upd_field;
    logic [VALUE_W-1:0] upd_value;
    logic               write;
    logic [3:0]         num;
    logic [3:0]         blob;
    logic               busy;
    logic               err_field;

    modport master (
        output upd_valid, upd_field, upd_value,
        input  upd_ready, write, num, blob, busy, err_field
    );

    modport slave (
        input  upd_valid, upd_field, upd_value,
        output upd_ready, write, num, blob, busy, err_field
    );
endinterface

// File: rtl/hud_digit_writer.sv
// rtl/hud_digit_writer.sv - binary to BCD HUD digit slot writer (optional HUD_LZ_BLANK_EN)
module hud_digit_writer #(
    parameter int DIGITS     = 4,
    parameter int NUM_FIELDS = 3,
    parameter int VALUE_W    = 14,
    parameter int MAX_VALUE  = 9999
) (
    input  logic             clk,
    input  logic             reset_n,
    hud_digit_writer_if.slave bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int ICNT_W = $clog2(VALUE_W + 1);
    localparam int DCNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WRITE} state_t;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [1:0]         field_q, field_d;
    logic [ICNT_W-1:0]  icnt_q, icnt_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               lead_q, lead_d;
    logic               ready_q, ready_d;
    logic               write_q, write_d;
    logic [3:0]         num_q, num_d;
    logic [3:0]         blob_q, blob_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               accept;
    logic               field_ok;
    logic [VALUE_W-1:0] sat_value;
    logic [BCD_W-1:0]   dd_bcd;
    logic [BCD_W-1:0]   iter_bcd;
    logic [VALUE_W-1:0] iter_bin;
    logic [BCD_W-1:0]   src_bcd;
    logic [3:0]         cur_digit;
    logic [3:0]         cur_glyph;

    assign accept    = bus.upd_valid && ready_q;
    assign field_ok  = int'(bus.upd_field) < NUM_FIELDS;
    assign sat_value = (bus.upd_value > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE)
                                                             : bus.upd_value;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit
    always_comb begin
        dd_bcd = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dd_bcd[4*i +: 4] >= 4'd5) begin
                dd_bcd[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
            end
        end
        iter_bcd = {dd_bcd[BCD_W-2:0], bin_q[VALUE_W-1]};
        iter_bin = {bin_q[VALUE_W-2:0], 1'b0};
    end

    // Digit about to be written: the last conversion step feeds the first write directly
    always_comb begin
        src_bcd   = (state_q == S_CONVERT) ? iter_bcd : bcd_q;
        cur_digit = src_bcd[BCD_W-1 -: 4];
`ifdef HUD_LZ_BLANK_EN
        // Position 0 on the conversion edge, otherwise the count of digits already written
        if (lead_q && (cur_digit == 4'd0) &&
            !((state_q == S_WRITE) && (dcnt_q == DCNT_W'(DIGITS - 1)))) begin
            cur_glyph = 4'd10;
        end else begin
            cur_glyph = cur_digit;
        end
`else
        cur_glyph = cur_digit;
`endif
    end

    // Next-state and registered-output logic of the IDLE/CONVERT/WRITE sequencer
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        field_d = field_q;
        icnt_d  = icnt_q;
        dcnt_d  = dcnt_q;
        lead_d  = lead_q;
        write_d = 1'b0;
        num_d   = num_q;
        blob_d  = blob_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (field_ok) begin
                        state_d = S_CONVERT;
                        bin_d   = sat_value;
                        bcd_d   = '0;
                        field_d = bus.upd_field;
                        icnt_d  = '0;
                        lead_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CONVERT: begin
                bin_d  = iter_bin;
                bcd_d  = iter_bcd;
                icnt_d = icnt_q + ICNT_W'(1);
                if (icnt_q == ICNT_W'(VALUE_W - 1)) begin
                    state_d = S_WRITE;
                    write_d = 1'b1;
                    num_d   = cur_glyph;
                    blob_d  = 4'(int'(field_q) * DIGITS);
                    bcd_d   = {iter_bcd[BCD_W-5:0], 4'd0};
                    dcnt_d  = DCNT_W'(1);
                    lead_d  = lead_q && (cur_digit == 4'd0);
                end
            end
            S_WRITE: begin
                if (dcnt_q == DCNT_W'(DIGITS)) begin
                    state_d = S_IDLE;
                end else begin
                    write_d = 1'b1;
                    num_d   = cur_glyph;
                    blob_d  = blob_q + 4'd1;
                    bcd_d   = {bcd_q[BCD_W-5:0], 4'd0};
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                    lead_d  = lead_q && (cur_digit == 4'd0);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any sequence in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            field_q <= '0;
            icnt_q  <= '0;
            dcnt_q  <= '0;
            lead_q  <= 1'b0;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            num_q   <= '0;
            blob_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            field_q <= field_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            lead_q  <= lead_d;
            ready_q <= ready_d;
            write_q <= write_d;
            num_q   <= num_d;
            blob_q  <= blob_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.upd_ready = ready_q;
    assign bus.write     = write_q;
    assign bus.num       = num_q;
    assign bus.blob      = blob_q;
    assign bus.busy      = busy_q;
    assign bus.err_field = err_q;
endmodule

// File: tb/tb_hud_digit_writer.sv
// tb/tb_hud_digit_writer.sv - directed scoreboard bench for hud_digit_writer
module tb_hud_digit_writer;
    localparam int DIGITS     = 4;
    localparam int NUM_FIELDS = 3;
    localparam int VALUE_W    = 14;
    localparam int MAX_VALUE  = 9999;
    localparam int FIRST_LAT  = VALUE_W;
    localparam int READY_LAT  = VALUE_W + DIGITS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wcount = 0;
    int   err_seen = 0;
    logic wr_prev = 1'b0;
    logic [7:0] exp_q[$];

    hud_digit_writer_if #(.VALUE_W(VALUE_W)) bus();

    hud_digit_writer #(
        .DIGITS(DIGITS), .NUM_FIELDS(NUM_FIELDS), .VALUE_W(VALUE_W), .MAX_VALUE(MAX_VALUE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, leading-zero rule applied to all but the LSD
    task automatic push_expected(input int field, input int value, input int count);
        int v;
        int pw;
        int dig;
        int nm;
        bit lead;
        v    = (value > MAX_VALUE) ? MAX_VALUE : value;
        pw   = 1;
        lead = 1'b1;
        for (int k = 1; k < DIGITS; k++) pw = pw * 10;
        for (int k = 0; k < DIGITS; k++) begin
            dig = (v / pw) % 10;
            nm  = dig;
`ifdef HUD_LZ_BLANK_EN
            if (lead && dig == 0 && k != DIGITS - 1) nm = 10;
`endif
            if (dig != 0) lead = 1'b0;
            if (k < count) exp_q.push_back({4'(field * DIGITS + k), 4'(nm)});
            pw = pw / 10;
        end
    endtask

    // Write monitor: pops the scoreboard and checks first-write latency
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.err_field) err_seen++;
        if (bus.write) begin
            if (!wr_prev) chk("first_write_latency", cyc - acc_cyc, FIRST_LAT);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.write), 0);
            end else begin
                e = exp_q.pop_front();
                chk("blob", 32'(bus.blob), 32'(e[7:4]));
                chk("num", 32'(bus.num), 32'(e[3:0]));
            end
            wcount++;
        end
        wr_prev = bus.write;
    end

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.upd_ready) break;
        end
        chk(tag, 32'(bus.upd_ready), 1);
    endtask

    task automatic send(input int field, input int value);
        wait_ready("ready_before_send");
        bus.upd_valid = 1'b1;
        bus.upd_field = 2'(field);
        bus.upd_value = VALUE_W'(value);
        if (field < NUM_FIELDS) push_expected(field, value, DIGITS);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        wait_ready(tag);
        chk({tag, "_latency"}, cyc - acc_cyc, READY_LAT);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        int base;
        bus.upd_valid = 1'b0;
        bus.upd_field = 2'd0;
        bus.upd_value = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_write", 32'(bus.write), 0);
        chk("rst_num", 32'(bus.num), 0);
        chk("rst_blob", 32'(bus.blob), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err_field), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(bus.upd_ready), 1);

        // 1234 into field 1
        send(1, 1234);
        chk("busy_after_accept", 32'(bus.busy), 1);
        chk("ready_low_after_accept", 32'(bus.upd_ready), 0);
        wait_idle("f1_1234");

        // Saturation, no error pulse
        base = err_seen;
        send(0, 16383);
        wait_idle("f0_sat");
        chk("sat_no_err", err_seen - base, 0);

        // Bad field: one-cycle error pulse, no writes, ready stays high
        base = wcount;
        send(3, 500);
        chk("err_pulse", 32'(bus.err_field), 1);
        chk("err_ready", 32'(bus.upd_ready), 1);
        chk("err_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("err_pulse_end", 32'(bus.err_field), 0);
        repeat (20) @(negedge clk);
        chk("err_no_writes", wcount - base, 0);

        // Leading zeros, zero, max, internal zero
        send(2, 7);
        wait_idle("f2_7");
        send(0, 0);
        wait_idle("f0_0");
        send(1, MAX_VALUE);
        wait_idle("f1_max");
        send(2, 105);
        wait_idle("f2_105");
        send(2, 10000);
        wait_idle("f2_10000");

        // Valid held through busy; value changes mid-busy
        wait_ready("hold_ready");
        bus.upd_valid = 1'b1;
        bus.upd_field = 2'd0;
        bus.upd_value = VALUE_W'(42);
        push_expected(0, 42, DIGITS);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        repeat (5) @(negedge clk);
        chk("hold_ready_low", 32'(bus.upd_ready), 0);
        bus.upd_value = VALUE_W'(77);
        push_expected(0, 77, DIGITS);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.upd_ready) break;
        end
        chk("hold_first_latency", cyc - acc_cyc, READY_LAT);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.upd_valid = 1'b0;
        chk("hold_second_accept", 32'(bus.busy), 1);
        wait_idle("hold_second");

        // Reset during the second write
        send(1, 5678);
        exp_q.delete();
        push_expected(1, 5678, 2);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.write) seen++;
            if (seen == 2) break;
        end
        chk("second_write_seen", seen, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_write_drop", 32'(bus.write), 0);
        chk("reset_busy_drop", 32'(bus.busy), 0);
        base = wcount;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", 32'(bus.upd_ready), 1);
        repeat (25) @(negedge clk);
        chk("no_writes_after_reset", wcount - base, 0);
        chk("reset_queue_drained", exp_q.size(), 0);

        // Recovery after reset
        send(0, 9);
        wait_idle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
